// File: rtl/fpu_instr_issue_pkg.sv
// Shared opcode constants, FSM state encoding and instruction classifier for the FPU issue stage.
package fpu_instr_issue_pkg;

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned STATE_W = 3;

    localparam logic [OPC_W-1:0] OPC_FP_OP  = 7'b1010011;
    localparam logic [OPC_W-1:0] OPC_FMADD  = 7'b1000011;
    localparam logic [OPC_W-1:0] OPC_FMSUB  = 7'b1000111;
    localparam logic [OPC_W-1:0] OPC_FNMSUB = 7'b1001011;
    localparam logic [OPC_W-1:0] OPC_FNMADD = 7'b1001111;
    localparam logic [OPC_W-1:0] OPC_CSR    = 7'b1110011;
    localparam logic [OPC_W-1:0] OPC_ADDI   = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ISSUE    = 3'd1;
    localparam state_t ST_WAIT_FPU = 3'd2;
    localparam state_t ST_CSR_GAP  = 3'd3;
    localparam state_t ST_HALT     = 3'd4;

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_FP    = 2'd1,
        CLS_CSR   = 2'd2,
        CLS_ALU   = 2'd3
    } instr_class_e;

    function automatic instr_class_e classify(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_FP_OP, OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: classify = CLS_FP;
            OPC_CSR:           classify = CLS_CSR;
            OPC_ADDI, OPC_LUI: classify = CLS_ALU;
            default:           classify = CLS_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/fpu_issue_fifo.sv
// Instruction buffer between host and issue FSM; power-of-two depth, pointers wrap naturally.
module fpu_issue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_c,
    output logic [AW:0]   count_o,
    output logic          full_c,
    output logic          empty_c
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_c = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_c  = (count_q == (AW+1)'(DEPTH));
    assign empty_c = (count_q == '0);

endmodule

// File: rtl/fpu_instr_issue.sv
// Issue stage ahead of int/FPU decode: buffers host instructions, holds FP ops, bubbles after CSR.
// Optional perf counters (perf_issued/perf_stall) are built when FPU_ISSUE_PERF_EN is defined.
module fpu_instr_issue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AW          = 2,
    parameter int unsigned CSR_BUBBLES = 2
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic [31:0]   instr_in,
    input  logic          instr_in_valid,
    output logic          instr_in_ready,
    input  logic          flush,
    input  logic          fpu_active,
    input  logic          fpu_complete,
    input  logic          halt_req,
    output logic [31:0]   instr_out,
    output logic          instr_out_valid,
    output logic          activation_signal,
    output logic          halted,
`ifdef FPU_ISSUE_PERF_EN
    output logic [31:0]   perf_issued,
    output logic [31:0]   perf_stall,
`endif
    output logic [AW:0]   count
);

    import fpu_instr_issue_pkg::*;

    localparam int unsigned IW = 32;
    localparam int unsigned GW = (CSR_BUBBLES < 2) ? 1 : $clog2(CSR_BUBBLES + 1);

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          fpu_done_q, fpu_done_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          halted_q, halted_d;
    logic [1:0]    act_q, act_d;

    logic          pop_c;
    logic          push_c;
    logic          advance_c;
    logic [IW-1:0] fifo_rdata_c;
    logic          fifo_full_c;
    logic          fifo_empty_c;
    instr_class_e  cls_c;
    logic          unused_fpu_active;

    // Completion is signalled by fpu_complete alone; fpu_active is informational.
    assign unused_fpu_active = fpu_active;

    assign cls_c          = classify(instr_q[6:0]);
    assign instr_in_ready = ~fifo_full_c | pop_c;
    assign push_c         = instr_in_valid & instr_in_ready & ~flush;

    fpu_issue_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (IW)
    ) u_fifo (
        .clk     (clk),
        .rst_l   (rst_l),
        .flush_i (flush),
        .push_i  (push_c),
        .wdata_i (instr_in),
        .pop_i   (pop_c),
        .rdata_c (fifo_rdata_c),
        .count_o (count),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        fpu_done_d = 1'b0;
        advance_c  = 1'b0;
        pop_c      = 1'b0;
        instr_d    = '0;
        valid_d    = 1'b0;
        halted_d   = 1'b0;
        act_d      = {act_q[0], (state_q == ST_ISSUE) && (cls_c == CLS_ALU)};

        case (state_q)
            ST_IDLE: advance_c = 1'b1;
            ST_ISSUE: begin
                if (cls_c == CLS_FP) begin
                    state_d    = ST_WAIT_FPU;
                    fpu_done_d = fpu_complete;
                end else if ((cls_c == CLS_CSR) && (CSR_BUBBLES != 0)) begin
                    state_d = ST_CSR_GAP;
                    gap_d   = GW'(CSR_BUBBLES);
                end else begin
                    advance_c = 1'b1;
                end
            end
            ST_WAIT_FPU: advance_c = fpu_complete | fpu_done_q;
            ST_CSR_GAP: begin
                gap_d     = gap_q - GW'(1);
                advance_c = (gap_d == '0);
            end
            ST_HALT: advance_c = 1'b0;
            default: state_d = ST_IDLE;
        endcase

        // Every exit from a busy state either issues the next entry or idles.
        if (advance_c) begin
            pop_c   = ~fifo_empty_c;
            state_d = fifo_empty_c ? ST_IDLE : ST_ISSUE;
        end

        if (halt_req) begin
            state_d = ST_HALT;
            pop_c   = 1'b0;
        end

        if (flush) begin
            state_d = ST_IDLE;
            pop_c   = 1'b0;
            gap_d   = '0;
            act_d   = '0;
        end

        if (state_d == ST_ISSUE) begin
            instr_d = fifo_rdata_c;
        end else if (state_d == ST_WAIT_FPU) begin
            instr_d = instr_q;
        end
        valid_d    = (state_d == ST_ISSUE) || (state_d == ST_WAIT_FPU);
        halted_d   = (state_d == ST_HALT);
        fpu_done_d = fpu_done_d && (state_d == ST_WAIT_FPU);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= ST_IDLE;
            gap_q      <= '0;
            fpu_done_q <= 1'b0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            act_q      <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            fpu_done_q <= fpu_done_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            act_q      <= act_d;
        end
    end

    assign instr_out         = instr_q;
    assign instr_out_valid   = valid_q;
    assign halted            = halted_q;
    assign activation_signal = act_q[1];

`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] issued_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            issued_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else if (flush) begin
            issued_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (state_q == ST_ISSUE) begin
                issued_cnt_q <= issued_cnt_q + 32'd1;
            end
            if ((state_q == ST_WAIT_FPU) || (state_q == ST_CSR_GAP)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_issued = issued_cnt_q;
    assign perf_stall  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_instr_issue.sv
// Directed plus random bench for fpu_instr_issue against a queue-based cycle model.
module tb_fpu_instr_issue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_LUI   = 32'h123450B7;
    localparam logic [31:0] I_FADD  = 32'h003100D3;
    localparam logic [31:0] I_CSRRW = 32'h00209073;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [31:0] instr_in;
    logic        instr_in_valid;
    logic        instr_in_ready;
    logic        flush;
    logic        fpu_active;
    logic        fpu_complete;
    logic        halt_req;
    logic [31:0] instr_out;
    logic        instr_out_valid;
    logic        activation_signal;
    logic        halted;
    logic [AW:0] count;

    always #5 clk = ~clk;

    fpu_instr_issue #(.DEPTH(DEPTH), .AW(AW), .CSR_BUBBLES(2)) dut (
        .clk               (clk),
        .rst_l             (rst_l),
        .instr_in          (instr_in),
        .instr_in_valid    (instr_in_valid),
        .instr_in_ready    (instr_in_ready),
        .flush             (flush),
        .fpu_active        (fpu_active),
        .fpu_complete      (fpu_complete),
        .halt_req          (halt_req),
        .instr_out         (instr_out),
        .instr_out_valid   (instr_out_valid),
        .activation_signal (activation_signal),
        .halted            (halted),
        .count             (count)
    );

    int tests = 0;
    int fails = 0;

    // Model: queue contents, what is being shown this cycle, and ALU issue timestamps.
    logic [31:0] mq[$];
    int          m_mode;   // 0 idle, 1 issuing m_cur, 2 holding FP m_cur, 3 CSR bubble, 4 halted
    logic [31:0] m_cur;
    int          m_gap;
    int          alu_at[$];
    int          cyc = 0;

    function automatic int cls(input logic [31:0] i);
        case (i[6:0])
            7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F: return 1;
            7'h73:        return 2;
            7'h13, 7'h37: return 3;
            default:      return 0;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  tab [8] = '{7'h53, 7'h43, 7'h73, 7'h13, 7'h37, 7'h33, 7'h03, 7'h4F};
        logic [31:0] r;
        r      = $urandom;
        r[6:0] = tab[$urandom_range(7)];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        instr_in_valid = 1'b0; instr_in = '0; flush = 1'b0;
        halt_req = 1'b0; fpu_complete = 1'b0; fpu_active = 1'b0;
        mq.delete(); alu_at.delete();
        m_mode = 0; m_gap = 0; m_cur = '0;
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
    endtask

    // One clock cycle: drive, check DUT against model, clock, advance model.
    task automatic step(input logic v, input logic [31:0] d, input logic fl,
                        input logic hr, input logic fc);
        bit          pop, done, ready_m, exp_act, exp_valid;
        int          nmode, ngap;
        logic [31:0] exp_out;
        @(negedge clk);
        instr_in_valid = v; instr_in = d; flush = fl; halt_req = hr;
        fpu_complete = fc; fpu_active = (m_mode == 2);

        nmode = m_mode; ngap = m_gap; pop = 0; done = 0;
        case (m_mode)
            0: done = 1;
            1: begin
                if (cls(m_cur) == 1) nmode = 2;
                else if (cls(m_cur) == 2) begin nmode = 3; ngap = 2; end
                else done = 1;
            end
            2: done = fc;
            3: begin ngap = m_gap - 1; done = (ngap == 0); end
            default: done = 0;
        endcase
        if (done) begin
            pop   = (mq.size() > 0);
            nmode = pop ? 1 : 0;
        end
        if (hr) begin nmode = 4; pop = 0; end
        if (fl) begin nmode = 0; pop = 0; ngap = 0; end
        ready_m = (mq.size() < DEPTH) || pop;

        exp_valid = (m_mode == 1) || (m_mode == 2);
        exp_out   = exp_valid ? m_cur : 32'h0;
        exp_act   = 0;
        foreach (alu_at[i]) if (alu_at[i] == cyc - 2) exp_act = 1;

        #1;
        chk("instr_out", instr_out, exp_out);
        chk("instr_out_valid", 32'(instr_out_valid), 32'(exp_valid));
        chk("activation_signal", 32'(activation_signal), 32'(exp_act));
        chk("halted", 32'(halted), 32'(m_mode == 4));
        chk("count", 32'(count), 32'(mq.size()));
        chk("instr_in_ready", 32'(instr_in_ready), 32'(ready_m));

        @(posedge clk);
        if (m_mode == 1 && cls(m_cur) == 3 && !fl) alu_at.push_back(cyc);
        if (fl) begin
            mq.delete();
            for (int i = alu_at.size() - 1; i >= 0; i--)
                if (alu_at[i] >= cyc - 1) alu_at.delete(i);
        end else begin
            if (pop) m_cur = mq.pop_front();
            if (v && ready_m) mq.push_back(d);
        end
        m_mode = nmode; m_gap = ngap; cyc++;
        while (alu_at.size() > 0 && alu_at[0] < cyc - 3) void'(alu_at.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_valid", 32'(instr_out_valid), 32'h0);
        chk("rst_act", 32'(activation_signal), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_ready", 32'(instr_in_ready), 32'h1);
        chk("rst_count", 32'(count), 32'h0);

        // ADDI then LUI back to back, strobes two cycles after each issue
        step(1, I_ADDI, 0, 0, 0);
        step(1, I_LUI, 0, 0, 0);
        #1 chk("t1_addi_issue", instr_out, I_ADDI);
        step(0, 0, 0, 0, 0);
        #1 chk("t1_lui_issue", instr_out, I_LUI);
        step(0, 0, 0, 0, 0);
        #1 chk("t1_act_addi", 32'(activation_signal), 32'h1);
        step(0, 0, 0, 0, 0);
        #1 chk("t1_act_lui", 32'(activation_signal), 32'h1);
        idle(3);

        // FADD held until fpu_complete five cycles after issue
        step(1, I_FADD, 0, 0, 0);
        step(1, I_ADDI, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0);
        #1 chk("t2_hold", instr_out, I_FADD);
        step(0, 0, 0, 0, 1);
        #1 chk("t2_next_issue", instr_out, I_ADDI);
        idle(4);

        // CSR followed by two bubbles
        step(1, I_CSRRW, 0, 0, 0);
        step(1, I_ADDI, 0, 0, 0);
        #1 chk("t3_csr_issue", instr_out, I_CSRRW);
        step(0, 0, 0, 0, 0);
        #1 chk("t3_bubble1", instr_out, 32'h0);
        step(0, 0, 0, 0, 0);
        #1 chk("t3_bubble2_valid", 32'(instr_out_valid), 32'h0);
        step(0, 0, 0, 0, 0);
        #1 chk("t3_addi_issue", instr_out, I_ADDI);
        idle(4);

        // Fill while FP is held, then push in the cycle of the pop
        step(1, I_FADD, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, I_ADDI, 0, 0, 0);
        step(1, I_LUI, 0, 0, 0);
        step(1, 32'h00000033, 0, 0, 0);
        step(1, 32'h00100113, 0, 0, 0);
        #1 chk("t4_full_count", 32'(count), 32'd4);
        chk("t4_full_ready", 32'(instr_in_ready), 32'h0);
        step(1, 32'h00200193, 0, 0, 1);
        #1 chk("t4_pushpop_count", 32'(count), 32'd4);
        idle(10);

        // Halt during WAIT_FPU, then flush
        step(1, I_FADD, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        #1 chk("t5_halted", 32'(halted), 32'h1);
        chk("t5_out_zero", instr_out, 32'h0);
        step(1, I_ADDI, 0, 0, 0);
        step(1, I_LUI, 0, 0, 0);
        idle(2);
        step(0, 0, 1, 0, 0);
        #1 chk("t5_flush_count", 32'(count), 32'h0);
        chk("t5_flush_halted", 32'(halted), 32'h0);
        idle(2);

        // Asynchronous reset in WAIT_FPU
        step(1, I_FADD, 0, 0, 0);
        step(1, I_ADDI, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        #2 rst_l = 1'b0;
        #1;
        chk("t6_rst_out", instr_out, 32'h0);
        chk("t6_rst_valid", 32'(instr_out_valid), 32'h0);
        chk("t6_rst_count", 32'(count), 32'h0);
        chk("t6_rst_halted", 32'(halted), 32'h0);
        do_reset();
        step(1, I_LUI, 0, 0, 0);
        idle(4);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            logic v, fl, hr, fc;
            v  = ($urandom_range(3) != 0);
            fl = (m_mode == 4) ? ($urandom_range(3) == 0) : ($urandom_range(59) == 0);
            hr = ($urandom_range(79) == 0);
            fc = (m_mode == 2) && ($urandom_range(2) == 0);
            step(v, rand_instr(), fl, hr, fc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
